// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: key codes, FSM state
// encodings and the operand ceiling derived from the digit count.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_ENT = 4'hE;

    // Encoding 2'd3 is unused and treated as an upset by the FSM.
    typedef enum logic [1:0] {
        ST_ENTRY_A = 2'd0,
        ST_ENTRY_B = 2'd1,
        ST_DONE    = 2'd2
    } calc_state_t;

    // Largest operand enterable with the given number of decimal digits.
    function automatic int calc_max(input int digits);
        int m;
        m = 1;
        for (int i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/keypad_calc_fsm_if.sv
// Keypad-to-calculator link plus the display-side outputs.
//
// Handshake: key_valid is a single-cycle strobe qualifying key_code. There is
// no ready: the calculator accepts every strobe, including back-to-back ones,
// and nothing is buffered. result_valid is a single-cycle strobe marking the
// cycle in which result/neg first carry a new value.
interface keypad_calc_fsm_if #(
    parameter int OPND_W = 7
);
    logic              key_valid;
    logic [3:0]        key_code;
    logic [OPND_W-1:0] opa;
    logic [OPND_W-1:0] opb;
    logic              op_sub;
    logic [OPND_W:0]   result;
    logic              neg;
    logic              result_valid;
    logic [1:0]        state;

    modport master (
        output key_valid, key_code,
        input  opa, opb, op_sub, result, neg, result_valid, state
    );

    modport slave (
        input  key_valid, key_code,
        output opa, opb, op_sub, result, neg, result_valid, state
    );
endinterface

// File: rtl/dec_digit_accum.sv
// Multi-digit decimal operand accumulator: value <- value*10 + d while fewer
// than DIGITS digits have been taken; leading zeros count as digits.
module dec_digit_accum
    import calc_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int OPND_W = 7,
    localparam int CNT_W = $clog2(DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_digit,
    input  logic              clear,
    input  logic              set_digit,
    input  logic [3:0]        digit,
    output logic [OPND_W-1:0] value
);

    localparam logic [OPND_W+3:0] MAX_EXT = (OPND_W + 4)'(calc_max(DIGITS));

    logic [CNT_W-1:0]  count;
    logic [OPND_W+3:0] ext;
    logic [OPND_W+3:0] prod;
    logic              accept;

    // Shift-add times ten at widened precision, then append the new digit.
    always_comb begin
        ext    = {4'b0000, value};
        prod   = (ext << 3) + (ext << 1) + {{OPND_W{1'b0}}, digit};
        accept = (count < CNT_W'(DIGITS)) && (prod <= MAX_EXT);
    end

    // Operand and digit-count registers; clear wins over set, set over load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (set_digit) begin
            value <= OPND_W'(digit);
            count <= CNT_W'(1);
        end else if (load_digit && accept) begin
            value <= prod[OPND_W-1:0];
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_calc_fsm.sv
// Keypad calculator controller: two decimal operands, add/sub operator,
// registered result on enter. Optional subtraction is enabled by defining
// CALC_SUB_EN; without it key B acts as add and op_sub/neg stay 0.
module keypad_calc_fsm
    import calc_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int OPND_W = 7
) (
    input logic               clk,
    input logic               rst,
    keypad_calc_fsm_if.slave  kif
);

    calc_state_t     state_q;
    logic            op_sub_q;
    logic [OPND_W:0] result_q;
    logic            neg_q;
    logic            result_valid_q;

    logic [OPND_W-1:0] opa;
    logic [OPND_W-1:0] opb;

    logic key_digit, key_op, key_op_sub, key_clr, key_ent, state_bad;
    logic [OPND_W:0] res_nxt;
    logic            neg_nxt;

    // Key decode; every strobe is consumed in the cycle it arrives.
    always_comb begin
        key_digit = kif.key_valid && (kif.key_code <= 4'd9);
        key_op    = kif.key_valid && ((kif.key_code == KEY_ADD) || (kif.key_code == KEY_SUB));
        key_clr   = kif.key_valid && (kif.key_code == KEY_CLR);
        key_ent   = kif.key_valid && (kif.key_code == KEY_ENT);
        state_bad = (2'(state_q) == 2'b11);
`ifdef CALC_SUB_EN
        key_op_sub = (kif.key_code == KEY_SUB);
`else
        key_op_sub = 1'b0;
`endif
    end

    dec_digit_accum #(.DIGITS(DIGITS), .OPND_W(OPND_W)) u_acc_a (
        .clk        (clk),
        .rst        (rst),
        .load_digit (key_digit && (state_q == ST_ENTRY_A)),
        .clear      (key_clr || state_bad),
        .set_digit  (key_digit && (state_q == ST_DONE)),
        .digit      (kif.key_code),
        .value      (opa)
    );

    dec_digit_accum #(.DIGITS(DIGITS), .OPND_W(OPND_W)) u_acc_b (
        .clk        (clk),
        .rst        (rst),
        .load_digit (key_digit && (state_q == ST_ENTRY_B)),
        .clear      (key_clr || state_bad
                     || (key_op && (state_q == ST_ENTRY_A))
                     || (key_digit && (state_q == ST_DONE))),
        .set_digit  (1'b0),
        .digit      (kif.key_code),
        .value      (opb)
    );

    // Result arithmetic: zero-extended sum, or magnitude and sign of difference.
    always_comb begin
`ifdef CALC_SUB_EN
        if (op_sub_q) begin
            neg_nxt = (opa < opb);
            res_nxt = neg_nxt ? ({1'b0, opb} - {1'b0, opa}) : ({1'b0, opa} - {1'b0, opb});
        end else begin
            neg_nxt = 1'b0;
            res_nxt = {1'b0, opa} + {1'b0, opb};
        end
`else
        neg_nxt = 1'b0;
        res_nxt = {1'b0, opa} + {1'b0, opb};
`endif
    end

    // Control FSM with operator, result, sign and result strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_ENTRY_A;
            op_sub_q       <= 1'b0;
            result_q       <= '0;
            neg_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (key_clr || state_bad) begin
                state_q  <= ST_ENTRY_A;
                op_sub_q <= 1'b0;
                result_q <= '0;
                neg_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_ENTRY_A: begin
                        if (key_op) begin
                            op_sub_q <= key_op_sub;
                            state_q  <= ST_ENTRY_B;
                        end
                    end
                    ST_ENTRY_B: begin
                        if (key_op) begin
                            op_sub_q <= key_op_sub;
                        end else if (key_ent) begin
                            result_q       <= res_nxt;
                            neg_q          <= neg_nxt;
                            result_valid_q <= 1'b1;
                            state_q        <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (key_digit) begin
                            state_q  <= ST_ENTRY_A;
                            op_sub_q <= 1'b0;
                            result_q <= '0;
                            neg_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_ENTRY_A;
                    end
                endcase
            end
        end
    end

    assign kif.opa          = opa;
    assign kif.opb          = opb;
    assign kif.op_sub       = op_sub_q;
    assign kif.result       = result_q;
    assign kif.neg          = neg_q;
    assign kif.result_valid = result_valid_q;
    assign kif.state        = 2'(state_q);

endmodule

// File: tb/tb_keypad_calc_fsm.sv
// Directed bench for keypad_calc_fsm with DIGITS=2, OPND_W=7.
module tb_keypad_calc_fsm;

    localparam int OPND_W = 7;
`ifdef CALC_SUB_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    keypad_calc_fsm_if #(.OPND_W(OPND_W)) kif ();

    keypad_calc_fsm #(.DIGITS(2), .OPND_W(OPND_W)) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    // Clock
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int rv_count     = 0;

    // Scoreboard entries are {neg, result}.
    logic [OPND_W+1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Driver: one key per cycle, back to back, then drop key_valid.
    // Returns on the negedge after the last key's clock edge.
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int c;
            c = int'(s[i]);
            @(negedge clk);
            kif.key_valid = 1'b1;
            kif.key_code  = (c >= 65) ? 4'(c - 55) : 4'(c - 48);
        end
        @(negedge clk);
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int a, input int b, input int sub,
                             input int res, input int ng, input int st);
        check({tag, ".opa"},    32'(kif.opa),    32'(a));
        check({tag, ".opb"},    32'(kif.opb),    32'(b));
        check({tag, ".op_sub"}, 32'(kif.op_sub), 32'(sub));
        check({tag, ".result"}, 32'(kif.result), 32'(res));
        check({tag, ".neg"},    32'(kif.neg),    32'(ng));
        check({tag, ".state"},  32'(kif.state),  32'(st));
    endtask

    // Scoreboard: every result strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (kif.result_valid === 1'b1) begin
            rv_count++;
            if (exp_q.size() == 0) begin
                check("sb_queue_nonempty", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [OPND_W+1:0] e;
                e = exp_q.pop_front();
                check("sb_result", 32'({kif.neg, kif.result}), 32'(e));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
        idle(3);
        check_all("in_reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(1);
        check_all("after_reset", 0, 0, 0, 0, 0, 0);
        check("after_reset.rv", 32'(kif.result_valid), 32'd0);

        // 12 + 34
        exp_q.push_back({1'b0, 8'd46});
        send("12A");
        check("t1_mid.state", 32'(kif.state), 32'd1);
        check("t1_mid.opa", 32'(kif.opa), 32'd12);
        send("34E");
        check_all("t1", 12, 34, 0, 46, 0, 2);
        check("t1.rv_high", 32'(kif.result_valid), 32'd1);
        idle(1);
        check("t1.rv_low", 32'(kif.result_valid), 32'd0);
        idle(1);
        check("t1.rv_count", 32'(rv_count), 32'd1);

        // Operator and enter are ignored in DONE
        send("AE");
        check("done_ign.state", 32'(kif.state), 32'd2);
        check("done_ign.result", 32'(kif.result), 32'd46);
        check("done_ign.rv", 32'(kif.result_valid), 32'd0);

        // Digit in DONE starts a new calculation
        send("8");
        check_all("done_digit", 8, 0, 0, 0, 0, 0);

        // Enter in ENTRY_A is ignored
        send("E");
        check("enter_a.state", 32'(kif.state), 32'd0);
        check("enter_a.opa", 32'(kif.opa), 32'd8);
        check("enter_a.rv", 32'(kif.result_valid), 32'd0);
        send("C");
        check_all("clr1", 0, 0, 0, 0, 0, 0);

        // Digit-count limit on both operands
        exp_q.push_back({1'b0, 8'd111});
        send("123A999E");
        check_all("t2", 12, 99, 0, 111, 0, 2);
        send("C");

        // 5 - 20 (or 5 + 20 without subtraction)
        exp_q.push_back(SUB ? {1'b1, 8'd15} : {1'b0, 8'd25});
        send("5B20E");
        check_all("t3", 5, 20, SUB, SUB ? 15 : 25, SUB, 2);
        send("C");

        // 99 - 99 (or 99 + 99)
        exp_q.push_back(SUB ? {1'b0, 8'd0} : {1'b0, 8'd198});
        send("99B99E");
        check_all("t4", 99, 99, SUB, SUB ? 0 : 198, 0, 2);
        send("C");

        // Operator replaced in ENTRY_B
        exp_q.push_back(SUB ? {1'b0, 8'd3} : {1'b0, 8'd11});
        send("7AB4E");
        check_all("t5", 7, 4, SUB, SUB ? 3 : 11, 0, 2);
        send("C");

        // Ignored codes, then clear mid-entry
        send("4A6");
        send("DF");
        check_all("ign_codes", 4, 6, 0, 0, 0, 1);
        send("C");
        check_all("clr2", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in ENTRY_B with a key strobe overlapping reset
        send("4A6");
        check("pre_rst.state", 32'(kif.state), 32'd1);
        @(negedge clk);
        rst           = 1'b1;
        kif.key_valid = 1'b1;
        kif.key_code  = 4'h9;
        #1;
        check("async_rst.state", 32'(kif.state), 32'd0);
        check("async_rst.opb", 32'(kif.opb), 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
        idle(1);
        check_all("post_rst", 0, 0, 0, 0, 0, 0);
        exp_q.push_back({1'b0, 8'd6});
        send("3A3E");
        check_all("t6", 3, 3, 0, 6, 0, 2);

        idle(2);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        check("rv_total", 32'(rv_count), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
